mult_add_seq: RTL and testbench



---
 rtl/mult_add_seq.sv | 152 +++++++++++++++
 tb/tb_mult_add_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_add_seq.sv
// Time-multiplexed dot product: LANES multipliers reused over ceil(TAPS/LANES) beats.
// Define MULT_ADD_SIGNED_EN for two's complement operands and a sign-extended result.
module mult_add_seq #(
    parameter int TAPS   = 9,
    parameter int DATA_W = 4,
    parameter int LANES  = 3,
    parameter int RES_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TAPS*DATA_W-1:0]   sample_in,
    input  logic [TAPS*DATA_W-1:0]   coeff_in,
    input  logic                     conv_en,
    output logic                     busy,
    output logic [RES_W-1:0]         result,
    output logic                     result_ready
);

    localparam int NBEATS    = (TAPS + LANES - 1) / LANES;
    localparam int BEAT_W    = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int OP_BITS   = TAPS * DATA_W;
    localparam int LANE_BITS = LANES * DATA_W;
    localparam int PAD_BITS  = NBEATS * LANE_BITS;
    localparam int PROD_W    = 2 * DATA_W;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);

    generate
        if (RES_W < 2 * DATA_W + $clog2(TAPS)) begin : g_res_w_check
            $error("mult_add_seq: RES_W too narrow for TAPS products of 2*DATA_W bits");
        end
        if (LANES < 1 || LANES > TAPS) begin : g_lanes_check
            $error("mult_add_seq: LANES must lie in 1..TAPS");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [BEAT_W-1:0]     beat;
    logic [RES_W-1:0]      acc;
    logic [RES_W-1:0]      acc_nxt;
    logic [RES_W-1:0]      beat_sum;
    logic [OP_BITS-1:0]    opnd_s;
    logic [OP_BITS-1:0]    opnd_c;
    logic [PAD_BITS-1:0]   pad_s;
    logic [PAD_BITS-1:0]   pad_c;
    logic [LANE_BITS-1:0]  win_s;
    logic [LANE_BITS-1:0]  win_c;

    // Zero taps past TAPS so a partial last beat adds nothing.
    generate
        if (PAD_BITS > OP_BITS) begin : g_pad
            assign pad_s = {{(PAD_BITS - OP_BITS){1'b0}}, opnd_s};
            assign pad_c = {{(PAD_BITS - OP_BITS){1'b0}}, opnd_c};
        end else begin : g_nopad
            assign pad_s = opnd_s;
            assign pad_c = opnd_c;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (conv_en) state_nxt = RUN;
            RUN:     if (beat == LAST_BEAT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_comb begin
        win_s = '0;
        win_c = '0;
        for (int b = 0; b < NBEATS; b++) begin
            if (beat == BEAT_W'(b)) begin
                win_s = pad_s[b*LANE_BITS +: LANE_BITS];
                win_c = pad_c[b*LANE_BITS +: LANE_BITS];
            end
        end
    end

    // Operands are widened to PROD_W first; the low PROD_W bits of that product
    // are correct for both unsigned and two's complement inputs.
    always_comb begin
        beat_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            logic [DATA_W-1:0] a;
            logic [DATA_W-1:0] c;
            logic [PROD_W-1:0] prod;
            a = win_s[l*DATA_W +: DATA_W];
            c = win_c[l*DATA_W +: DATA_W];
`ifdef MULT_ADD_SIGNED_EN
            prod     = {{DATA_W{a[DATA_W-1]}}, a} * {{DATA_W{c[DATA_W-1]}}, c};
            beat_sum = beat_sum + RES_W'($signed(prod));
`else
            prod     = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, c};
            beat_sum = beat_sum + RES_W'(prod);
`endif
        end
    end

    assign acc_nxt = acc + beat_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat         <= '0;
            acc          <= '0;
            opnd_s       <= '0;
            opnd_c       <= '0;
            result       <= '0;
            result_ready <= 1'b0;
        end else begin
            result_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (conv_en) begin
                        opnd_s <= sample_in;
                        opnd_c <= coeff_in;
                        acc    <= '0;
                        beat   <= '0;
                    end
                end
                RUN: begin
                    acc  <= acc_nxt;
                    beat <= beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        result       <= acc_nxt;
                        result_ready <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_add_seq.sv
// Directed bench for mult_add_seq: three instances (LANES 3, 9, 2) share stimulus;
// each has its own expected-result queue checked by a negedge monitor.
module tb_mult_add_seq;

    localparam int TAPS   = 9;
    localparam int DATA_W = 4;
    localparam int RES_W  = 16;
    localparam int NB [3] = '{3, 1, 5};

`ifdef MULT_ADD_SIGNED_EN
    localparam logic [15:0] E_MAX  = 16'h0009;
    localparam logic [15:0] E_RAMP = 16'd20;
    localparam logic [15:0] E_NEG  = 16'hFE08;
`else
    localparam logic [15:0] E_MAX  = 16'd2025;
    localparam logic [15:0] E_RAMP = 16'd36;
    localparam logic [15:0] E_NEG  = 16'h01F8;
`endif

    logic                    clk;
    logic                    rst;
    logic [TAPS*DATA_W-1:0]  sample_in;
    logic [TAPS*DATA_W-1:0]  coeff_in;
    logic                    conv_en;
    logic [2:0]              busy_v;
    logic [2:0]              rdy_v;
    logic [RES_W-1:0]        res [3];

    logic [RES_W-1:0]        exp_q [3][$];
    int                      edge_q [3][$];
    logic [RES_W-1:0]        last_res [3];
    int                      edge_cnt;
    int                      checks;
    int                      errors;

    mult_add_seq #(.TAPS(TAPS), .DATA_W(DATA_W), .LANES(3), .RES_W(RES_W)) u_l3 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .coeff_in(coeff_in), .conv_en(conv_en),
        .busy(busy_v[0]), .result(res[0]), .result_ready(rdy_v[0]));

    mult_add_seq #(.TAPS(TAPS), .DATA_W(DATA_W), .LANES(9), .RES_W(RES_W)) u_l9 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .coeff_in(coeff_in), .conv_en(conv_en),
        .busy(busy_v[1]), .result(res[1]), .result_ready(rdy_v[1]));

    mult_add_seq #(.TAPS(TAPS), .DATA_W(DATA_W), .LANES(2), .RES_W(RES_W)) u_l2 (
        .clk(clk), .rst(rst), .sample_in(sample_in), .coeff_in(coeff_in), .conv_en(conv_en),
        .busy(busy_v[2]), .result(res[2]), .result_ready(rdy_v[2]));

    // clock / edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // monitor: pops expectations on result_ready, otherwise checks result holds
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [RES_W-1:0] e;
            int               ed;
            if (rst) begin
                checks++;
                if (res[i] !== '0 || rdy_v[i] !== 1'b0 || busy_v[i] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_values inst%0d: result=%h ready=%b busy=%b, want 0 0 0",
                             i, res[i], rdy_v[i], busy_v[i]);
                end
                last_res[i] = '0;
            end else if (rdy_v[i]) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ready inst%0d: result=%h at edge %0d, none expected",
                             i, res[i], edge_cnt);
                end else begin
                    e  = exp_q[i].pop_front();
                    ed = edge_q[i].pop_front();
                    if (res[i] !== e || edge_cnt != ed) begin
                        errors++;
                        $display("FAIL result inst%0d: got %h at edge %0d, want %h at edge %0d",
                                 i, res[i], edge_cnt, e, ed);
                    end
                end
                last_res[i] = res[i];
            end else begin
                checks++;
                if (res[i] !== last_res[i]) begin
                    errors++;
                    $display("FAIL result_hold inst%0d: got %h, want %h", i, res[i], last_res[i]);
                end
            end
        end
    end

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    task automatic start_run(input logic [TAPS*DATA_W-1:0] s, input logic [TAPS*DATA_W-1:0] c,
                             input logic [RES_W-1:0] e);
        @(posedge clk);
        #1;
        sample_in = s;
        coeff_in  = c;
        conv_en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_q[i].push_back(e);
            edge_q[i].push_back(edge_cnt + 1 + NB[i]);
        end
        @(posedge clk);
        #1;
        conv_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_v != 3'b000 || exp_q[0].size() != 0 || exp_q[1].size() != 0 ||
                exp_q[2].size() != 0) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b pending=%0d/%0d/%0d, want idle with none pending",
                     busy_v, exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic flush_expected();
        for (int i = 0; i < 3; i++) begin
            exp_q[i].delete();
            edge_q[i].delete();
        end
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        rst       = 1'b0;
        conv_en   = 1'b0;
        sample_in = '0;
        coeff_in  = '0;
        for (int i = 0; i < 3; i++) last_res[i] = '0;

        // reset asserted and released away from clock edges
        #3  rst = 1'b1;
        #19 rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("post_reset_result inst%0d", i), 32'(res[i]), 32'd0);
            check($sformatf("post_reset_ready inst%0d", i), 32'(rdy_v[i]), 32'd0);
            check($sformatf("post_reset_busy inst%0d", i), 32'(busy_v[i]), 32'd0);
        end

        // zeros, with busy window for LANES=3 (high after edges k..k+3)
        start_run('0, '0, 16'd0);
        check("busy_l3 edge k", 32'(busy_v[0]), 32'd1);
        for (int j = 1; j <= 4; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("busy_l3 edge k+%0d", j), 32'(busy_v[0]), (j < 4) ? 32'd1 : 32'd0);
        end
        wait_idle();

        start_run(36'h123132231, 36'h321312123, 16'd31);
        wait_idle();
        start_run({36{1'b1}}, {36{1'b1}}, E_MAX);
        wait_idle();
        start_run(36'h876543210, 36'h111111111, E_RAMP);
        wait_idle();
        start_run(36'h876543210, 36'h012345678, 16'd84);
        wait_idle();
        start_run({9{4'h8}}, {9{4'h7}}, E_NEG);
        wait_idle();

        // conv_en held for 10 edges: a restart only from IDLE, period NBEATS+2
        @(posedge clk);
        #1;
        sample_in = 36'h123132231;
        coeff_in  = 36'h321312123;
        conv_en   = 1'b1;
        n = edge_cnt;
        for (int i = 0; i < 3; i++) begin
            for (int s = n + 1; s <= n + 10; s += NB[i] + 2) begin
                exp_q[i].push_back(16'd31);
                edge_q[i].push_back(s + NB[i]);
            end
        end
        repeat (10) @(posedge clk);
        #1;
        conv_en = 1'b0;
        wait_idle();

        // operands change after the start edge: latched values are used
        start_run(36'h876543210, 36'h012345678, 16'd84);
        sample_in = {36{1'b1}};
        coeff_in  = 36'h0;
        wait_idle();

        // abort mid-run: no pulse, result cleared
        start_run(36'h123132231, 36'h321312123, 16'd31);
        @(posedge clk);
        #2;
        rst = 1'b1;
        flush_expected();
        #5 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort_result inst%0d", i), 32'(res[i]), 32'd0);
            check($sformatf("abort_busy inst%0d", i), 32'(busy_v[i]), 32'd0);
        end

        // recovery after abort
        start_run(36'h123132231, 36'h321312123, 16'd31);
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
